ram8_arbiter: RTL
=================

Name: ram8_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one 8-word x 16-bit register memory (DMux8Way/Register/Mux8Way16 style, synchronous write, combinational read).
- Lets requesters A and B share the memory through a req/ack handshake.
- Drives the memory's in/load/address and captures its out.
- Optionally runs a clear sweep of all 8 words after reset.

Parameters:
- DATA_WIDTH, 16, word width of memory and requester data.
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH (8).

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A word address
- a_wdata  in  DATA_WIDTH  A write data
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  DATA_WIDTH  A read data, valid while a_ack=1, held after
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B
- mem_in  out  DATA_WIDTH  to memory data input
- mem_load  out  1  to memory load
- mem_address  out  ADDR_WIDTH  to memory address
- mem_out  in  DATA_WIDTH  from memory output (combinational read)
- ready  out  1  high when arbiter is not in INIT

Behaviour:
- Reset (reset_n=0, immediate, asynchronous):
  - State -> INIT if OPTIONAL feature compiled in, else IDLE.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, mem_load=0, mem_address=0, mem_in=0, last_grant=B, clear counter=0.
  - Reset mid-transaction aborts it: no ack, and no write once reset is asserted.
- States: INIT, IDLE, SERVE, DONE.
- IDLE: sample a_req/b_req at the clock edge.
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last_grant; last_grant=B after reset, so A wins the first tie.
  - Latch grantee's we/addr/wdata into internal registers; set last_grant; go to SERVE.
  - No request: stay in IDLE.
- SERVE (1 cycle):
  - mem_address = latched addr; mem_in = latched wdata; mem_load = latched we.
  - Write: commits at the edge ending SERVE.
  - Read: mem_out registered into grantee's rdata at that edge; other rdata unchanged.
  - Go to DONE.
- DONE (1 cycle):
  - Grantee's ack=1; mem_load=0.
  - Requests ignored. Go to IDLE.
- Latency: request sampled at edge N -> ack high during cycle N+2. Max throughput: 1 transaction per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack is seen.
  - req still high in the first IDLE cycle after DONE = new transaction.
  - Write ack leaves rdata unchanged.
- Outside SERVE/INIT: mem_load=0, mem_address=0, mem_in=0 (all registered or decoded from state, glitch-free).
- Starvation bound: with both requesting continuously, grants alternate A,B,A,B; each waits at most 6 cycles.
- Address wrap: not applicable. All 8 addresses are legal; full ADDR_WIDTH passed unchanged.
- ack is never asserted for the non-granted requester.
- a_ack and b_ack are never high in the same cycle.

Optional Feature:
- Macro: RAM8_ARB_INIT_CLEAR_EN
- Defined:
  - After reset_n rises, state INIT for 8 cycles with mem_load=1, mem_in=0, mem_address=counter 0..7.
  - ready=0 throughout; requests held pending, not acked.
  - After address 7 is written: go to IDLE, ready=1.
- Undefined:
  - No INIT state; reset goes straight to IDLE.
  - ready=1 whenever reset_n=1.
  - Memory contents after reset are undefined.

Test Plan:
- Single write then read:
  - A writes 0xBEEF to addr 5; A_ack in cycle N+2.
  - A reads addr 5 -> a_rdata=0xBEEF with a_ack; b_ack stays 0.
- Simultaneous first requests:
  - a_req=b_req=1 in same IDLE (A write addr1=0x1111, B write addr2=0x2222).
  - A acked first, B acked 3 cycles later; reads return 0x1111/0x2222.
- Continuous contention:
  - Both hold req high for 12 cycles -> grant order A,B,A,B.
  - Exactly 4 acks; acks never overlap.
- Reset mid-op:
  - B write 0x5A5A addr 3 issued; reset_n low during SERVE before the edge.
  - No b_ack, outputs go to reset values immediately.
  - Without macro: addr 3 value unchanged from prior write 0x0003.
  - With macro: addr 3 reads 0x0000 after INIT.
- Init clear (macro defined):
  - Preload all words 0xFFFF, pulse reset_n.
  - ready=0 for 8 cycles, mem_address 0..7 with mem_load=1.
  - Then each read of addr 0..7 returns 0x0000.
  - An a_req raised during INIT is acked only after ready=1.

Source files
------------

// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of an 8x16 register memory.
// Define RAM8_ARB_INIT_CLEAR_EN to zero every word in an INIT sweep after reset.
module ram8_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_load,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  ready
);

    // state | meaning
    // INIT  | post-reset sweep writing zero to every word (optional build only)
    // IDLE  | waiting for a request; arbitration happens on the sampling edge
    // SERVE | latched address/data/we presented to the memory for one cycle
    // DONE  | one-cycle ack to the grantee; requests ignored
    typedef enum logic [1:0] {INIT, IDLE, SERVE, DONE} state_t;

`ifdef RAM8_ARB_INIT_CLEAR_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                state_q, state_d;
    logic                  grant_b_q, grant_b_d;   // last grantee, also the one in flight
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  pick_b;
`ifdef RAM8_ARB_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // On a tie the requester that did not win last time gets the grant.
    assign pick_b = b_req && (!a_req || !grant_b_q);

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef RAM8_ARB_INIT_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            INIT: begin
`ifdef RAM8_ARB_INIT_CLEAR_EN
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                if (a_req || b_req) begin
                    grant_b_d = pick_b;
                    we_d      = pick_b ? b_we    : a_we;
                    addr_d    = pick_b ? b_addr  : a_addr;
                    wdata_d   = pick_b ? b_wdata : a_wdata;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (!we_q) begin
                    if (grant_b_q) begin
                        b_rdata_d = mem_out;
                    end else begin
                        a_rdata_d = mem_out;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            grant_b_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

`ifdef RAM8_ARB_INIT_CLEAR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    // Memory controls are decoded from registered state only, so they are quiet outside SERVE/INIT.
    always_comb begin
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        if (state_q == SERVE) begin
            mem_load    = we_q;
            mem_address = addr_q;
            mem_in      = wdata_q;
        end
`ifdef RAM8_ARB_INIT_CLEAR_EN
        else if (state_q == INIT) begin
            // Held off while reset is asserted so no word is written during reset.
            mem_load    = reset_n;
            mem_address = clr_cnt_q;
        end
`endif
    end

    assign a_ack   = (state_q == DONE) && !grant_b_q;
    assign b_ack   = (state_q == DONE) && grant_b_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign ready   = (state_q != INIT);

endmodule
